// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core register file: default widths,
// architectural register indices and the byte-enable merge helper.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_V0   = 2;
  localparam int REG_A0   = 4;

  // Widest supported register; callers zero-extend into it and truncate back.
  localparam int MERGE_W  = 128;
  localparam int MERGE_B  = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0] old_v,
    input logic [MERGE_W-1:0] new_v,
    input logic [MERGE_B-1:0] be
  );
    logic [MERGE_W-1:0] r;
    r = old_v;
    for (int k = 0; k < MERGE_B; k++)
      if (be[k]) r[k*8 +: 8] = new_v[k*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: address mux over storage plus optional same-cycle
// write bypass using the same port-0-over-port-1 byte priority as commit.
module regfile_rd_port
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int DEPTH  = 1 << ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic [DEPTH-1:0][DATA_W-1:0] mem,
  input  logic [DEPTH-1:0]             busy,
  input  logic [ADDR_W-1:0]            addr,
  input  logic                         we0,
  input  logic [ADDR_W-1:0]            waddr0,
  input  logic [DATA_W-1:0]            wdata0,
  input  logic [DATA_W/8-1:0]          wbe0,
  input  logic                         we1,
  input  logic [ADDR_W-1:0]            waddr1,
  input  logic [DATA_W-1:0]            wdata1,
  input  logic [DATA_W/8-1:0]          wbe1,
  output logic [DATA_W-1:0]            data,
  output logic                         busy_o
);

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0]   o,
    input logic [DATA_W-1:0]   n,
    input logic [DATA_W/8-1:0] be
  );
    return DATA_W'(byte_merge(MERGE_W'(o), MERGE_W'(n), MERGE_B'(be)));
  endfunction

  always_comb begin
    data = mem[addr];
    if (BYPASS != 0) begin
      // port 1 first so port 0 overrides overlapping bytes
      if (we1 && waddr1 == addr) data = merge_bytes(data, wdata1, wbe1);
      if (we0 && waddr0 == addr) data = merge_bytes(data, wdata0, wbe0);
    end
    if (addr == '0) data = '0;
  end

  assign busy_o = (addr == '0) ? 1'b0 : busy[addr];

endmodule

// File: rtl/regfile_mp.sv
// Multi-port MIPS register file: NUM_RD read ports, two byte-enabled write
// ports, busy scoreboard for multi-cycle producers, $v0/$a0 debug taps.
module regfile_mp
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       we0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          waddr0,
  input  logic [ADDR_W-1:0]          waddr1,
  input  logic [DATA_W-1:0]          wdata0,
  input  logic [DATA_W-1:0]          wdata1,
  input  logic [DATA_W/8-1:0]        wbe0,
  input  logic [DATA_W/8-1:0]        wbe1,
  input  logic                       mark_en,
  input  logic [ADDR_W-1:0]          mark_addr,
  output logic [DATA_W-1:0]          v0,
  output logic [DATA_W-1:0]          a0
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] V0_IDX = ADDR_W'(REG_V0);
  localparam logic [ADDR_W-1:0] A0_IDX = ADDR_W'(REG_A0);

  logic [DEPTH-1:0][DATA_W-1:0] mem, mem_nxt;
  logic [DEPTH-1:0]             busy, busy_nxt;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0]   o,
    input logic [DATA_W-1:0]   n,
    input logic [DATA_W/8-1:0] be
  );
    return DATA_W'(byte_merge(MERGE_W'(o), MERGE_W'(n), MERGE_B'(be)));
  endfunction

  always_comb begin
    mem_nxt  = mem;
    busy_nxt = busy;
    for (int r = 1; r < DEPTH; r++) begin
      if (we1 && waddr1 == ADDR_W'(r)) begin
        mem_nxt[r]  = merge_bytes(mem_nxt[r], wdata1, wbe1);
        busy_nxt[r] = 1'b0;
      end
      if (we0 && waddr0 == ADDR_W'(r)) begin
        mem_nxt[r]  = merge_bytes(mem_nxt[r], wdata0, wbe0);
        busy_nxt[r] = 1'b0;
      end
      // a fresh mark wins over a same-cycle write: a new producer is pending
      if (mark_en && mark_addr == ADDR_W'(r)) busy_nxt[r] = 1'b1;
    end
    mem_nxt[REG_ZERO]  = '0;
    busy_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem  <= '0;
      busy <= '0;
    end else begin
      mem  <= mem_nxt;
      busy <= busy_nxt;
    end
  end

  genvar i;
  generate
    for (i = 0; i < NUM_RD; i++) begin : g_rd
      regfile_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .BYPASS (BYPASS)
      ) u_port (
        .mem    (mem),
        .busy   (busy),
        .addr   (rd_addr[i*ADDR_W +: ADDR_W]),
        .we0    (we0),
        .waddr0 (waddr0),
        .wdata0 (wdata0),
        .wbe0   (wbe0),
        .we1    (we1),
        .waddr1 (waddr1),
        .wdata1 (wdata1),
        .wbe1   (wbe1),
        .data   (rd_data[i*DATA_W +: DATA_W]),
        .busy_o (rd_busy[i])
      );
    end
  endgenerate

  assign v0 = mem[V0_IDX];
  assign a0 = mem[A0_IDX];

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing
// instance share the same stimulus so both read behaviours are checked.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic        we0, we1, mark_en;
  logic [4:0]  waddr0, waddr1, mark_addr;
  logic [31:0] wdata0, wdata1;
  logic [3:0]  wbe0, wbe1;

  logic [63:0] rdata_b, rdata_n;
  logic [1:0]  rbusy_b, rbusy_n;
  logic [31:0] v0_b, a0_b, v0_n, a0_n;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rdata_b), .rd_busy(rbusy_b),
    .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1), .wbe0(wbe0), .wbe1(wbe1),
    .mark_en(mark_en), .mark_addr(mark_addr), .v0(v0_b), .a0(a0_b)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0)) u_nob (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rdata_n), .rd_busy(rbusy_n),
    .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1), .wbe0(wbe0), .wbe1(wbe1),
    .mark_en(mark_en), .mark_addr(mark_addr), .v0(v0_n), .a0(a0_n)
  );

  task automatic idle();
    we0 = 0; we1 = 0; mark_en = 0;
    waddr0 = 0; waddr1 = 0; mark_addr = 0;
    wdata0 = 0; wdata1 = 0; wbe0 = 0; wbe1 = 0;
  endtask

  // commit at the rising edge, then settle inputs clear of the edge
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d);
    idle(); we0 = 1; waddr0 = a; wdata0 = d; wbe0 = 4'hF;
    tick(); idle(); #1;
  endtask

  task automatic test_reset();
    idle(); rd_addr = {5'd4, 5'd2}; rst_n = 0;
    tick(); tick(); rst_n = 1; #1;
    n_tests++;
    if ({rdata_b, rdata_n, v0_b, a0_b, v0_n, a0_n, rbusy_b, rbusy_n} !== '0) begin
      n_fail++; $display("FAIL reset_state: got rd=%h/%h v0a0=%h%h busy=%b%b want all 0",
                         rdata_b, rdata_n, v0_b, a0_b, rbusy_b, rbusy_n);
    end
  endtask

  task automatic test_basic_write();
    wr0(5'd2, 32'h12345678);
    wr0(5'd4, 32'hABCDEF01);
    rd_addr = {5'd4, 5'd2}; #1;
    n_tests++;
    if ({v0_b, a0_b, v0_n, a0_n} !== {2{32'h12345678, 32'hABCDEF01}}) begin
      n_fail++; $display("FAIL taps: got v0=%h a0=%h want 12345678 abcdef01", v0_b, a0_b);
    end
    n_tests++;
    if (rdata_b !== 64'hABCDEF01_12345678 || rdata_n !== 64'hABCDEF01_12345678) begin
      n_fail++; $display("FAIL basic_read: got %h/%h want abcdef0112345678", rdata_b, rdata_n);
    end
    rst_n = 0; tick(); rst_n = 1; #1;
    n_tests++;
    if ({rdata_b, rdata_n, v0_b, a0_b, v0_n, a0_n} !== '0) begin
      n_fail++; $display("FAIL rereset: got rd=%h/%h v0=%h a0=%h want 0", rdata_b, rdata_n, v0_b, a0_b);
    end
  endtask

  task automatic test_zero_reg();
    idle(); rd_addr = {5'd0, 5'd0};
    we0 = 1; we1 = 1; wdata0 = '1; wdata1 = '1; wbe0 = 4'hF; wbe1 = 4'hF;
    mark_en = 1; #1;
    n_tests++;
    if (rdata_b !== 64'h0 || rbusy_b !== 2'b00) begin
      n_fail++; $display("FAIL zero_bypass: got %h busy %b want 0", rdata_b, rbusy_b);
    end
    tick(); idle(); #1;
    n_tests++;
    if ({rdata_b, rdata_n, rbusy_b, rbusy_n} !== '0) begin
      n_fail++; $display("FAIL zero_after: got %h/%h busy %b%b want 0", rdata_b, rdata_n, rbusy_b, rbusy_n);
    end
  endtask

  task automatic test_byte_collision();
    wr0(5'd5, 32'h11223344);
    rd_addr = {5'd5, 5'd5};
    we0 = 1; waddr0 = 5; wdata0 = 32'hAAAAAAAA; wbe0 = 4'b0011;
    we1 = 1; waddr1 = 5; wdata1 = 32'hBBBBBBBB; wbe1 = 4'b0110; #1;
    n_tests++;
    if (rdata_b !== {2{32'h11BBAAAA}} || rdata_n !== {2{32'h11223344}}) begin
      n_fail++; $display("FAIL collision_same_cycle: got %h/%h want 11bbaaaa/11223344", rdata_b[31:0], rdata_n[31:0]);
    end
    tick(); idle(); #1;
    n_tests++;
    if (rdata_b !== {2{32'h11BBAAAA}} || rdata_n !== {2{32'h11BBAAAA}}) begin
      n_fail++; $display("FAIL collision_commit: got %h/%h want 11bbaaaa", rdata_b[31:0], rdata_n[31:0]);
    end
  endtask

  task automatic test_bypass();
    wr0(5'd7, 32'h01020304);
    rd_addr = {5'd7, 5'd7};
    we0 = 1; waddr0 = 7; wdata0 = 32'hCAFEF00D; wbe0 = 4'hF; #1;
    n_tests++;
    if (rdata_b !== {2{32'hCAFEF00D}}) begin
      n_fail++; $display("FAIL bypass_on: got %h want cafef00d", rdata_b);
    end
    n_tests++;
    if (rdata_n !== {2{32'h01020304}}) begin
      n_fail++; $display("FAIL bypass_off_old: got %h want 01020304", rdata_n);
    end
    tick(); idle(); #1;
    n_tests++;
    if (rdata_n !== {2{32'hCAFEF00D}}) begin
      n_fail++; $display("FAIL bypass_off_new: got %h want cafef00d", rdata_n);
    end
  endtask

  task automatic test_scoreboard();
    idle(); rd_addr = {5'd8, 5'd8}; mark_en = 1; mark_addr = 8; #1;
    n_tests++;
    if ({rbusy_b, rbusy_n} !== 4'b0000) begin
      n_fail++; $display("FAIL busy_early: got %b%b want 0000", rbusy_b, rbusy_n);
    end
    tick(); idle(); #1;
    n_tests++;
    if ({rbusy_b, rbusy_n} !== 4'b1111) begin
      n_fail++; $display("FAIL busy_set: got %b%b want 1111", rbusy_b, rbusy_n);
    end
    we1 = 1; waddr1 = 8; wdata1 = 32'h5; wbe1 = 4'hF; #1;
    n_tests++;
    if ({rbusy_b, rbusy_n} !== 4'b1111) begin
      n_fail++; $display("FAIL busy_not_bypassed: got %b%b want 1111", rbusy_b, rbusy_n);
    end
    tick(); idle(); #1;
    n_tests++;
    if ({rbusy_b, rbusy_n} !== 4'b0000 || rdata_n !== {2{32'h5}}) begin
      n_fail++; $display("FAIL busy_clear: got busy %b%b data %h want 0000 5", rbusy_b, rbusy_n, rdata_n[31:0]);
    end
    rd_addr = {5'd9, 5'd9};
    mark_en = 1; mark_addr = 9; we0 = 1; waddr0 = 9; wdata0 = 32'h99; wbe0 = 4'hF;
    tick(); idle(); #1;
    n_tests++;
    if ({rbusy_b, rbusy_n} !== 4'b1111 || rdata_n !== {2{32'h99}}) begin
      n_fail++; $display("FAIL mark_write_collide: got busy %b%b data %h want 1111 99", rbusy_b, rbusy_n, rdata_n[31:0]);
    end
    we0 = 1; waddr0 = 9; wdata0 = 32'hFFFFFFFF; wbe0 = 4'h0;
    tick(); idle(); #1;
    n_tests++;
    if ({rbusy_b, rbusy_n} !== 4'b0000 || rdata_n !== {2{32'h99}}) begin
      n_fail++; $display("FAIL zero_be_write: got busy %b%b data %h want 0000 99", rbusy_b, rbusy_n, rdata_n[31:0]);
    end
  endtask

  task automatic test_reset_mid();
    idle(); mark_en = 1; mark_addr = 3; tick();
    idle(); mark_en = 1; mark_addr = 6; tick();
    wr0(5'd10, 32'h0000DEAD);
    rd_addr = {5'd6, 5'd3}; #1;
    n_tests++;
    if ({rbusy_b, rbusy_n} !== 4'b1111) begin
      n_fail++; $display("FAIL mid_pre_busy: got %b%b want 1111", rbusy_b, rbusy_n);
    end
    rst_n = 0; we0 = 1; waddr0 = 11; wdata0 = 32'h1234; wbe0 = 4'hF;
    mark_en = 1; mark_addr = 12;
    tick(); rst_n = 1; idle(); #1;
    n_tests++;
    if ({rbusy_b, rbusy_n, rdata_n} !== '0) begin
      n_fail++; $display("FAIL mid_busy_cleared: got busy %b%b data %h want 0", rbusy_b, rbusy_n, rdata_n);
    end
    rd_addr = {5'd12, 5'd10}; #1;
    n_tests++;
    if (rdata_n[31:0] !== 32'h0 || rbusy_n[1] !== 1'b0) begin
      n_fail++; $display("FAIL mid_reg10: got %h busy12 %b want 0 0", rdata_n[31:0], rbusy_n[1]);
    end
    rd_addr = {5'd11, 5'd11}; #1;
    n_tests++;
    if (rdata_n !== 64'h0 || rdata_b !== 64'h0) begin
      n_fail++; $display("FAIL mid_write_dropped: got %h/%h want 0", rdata_b, rdata_n);
    end
  endtask

  initial begin
    idle(); rst_n = 0; rd_addr = '0;
    #2;
    test_reset();
    test_basic_write();
    test_zero_reg();
    test_byte_collision();
    test_bypass();
    test_scoreboard();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
